// File: rtl/sr_enc_pkg.sv
// sr_enc_pkg
//   Shared definitions for sr_pulse_encoder:
//     state_e    - encoder FSM states (IDLE, PULSE, HOLD)
//     tmr_width  - width of the shared pulse/holdoff down-counter,
//                  $clog2(max(PULSE_W, HOLDOFF) + 1)
package sr_enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic int tmr_width(input int pulse_w, input int holdoff);
    int mx;
    mx = (pulse_w > holdoff) ? pulse_w : holdoff;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/sr_pulse_encoder.sv
// sr_pulse_encoder
//   Command-side driver for an SR flip-flop sharing clk/rst. It accepts
//   target-level requests on a valid/ready handshake and emits registered,
//   mutually exclusive S or R pulses of PULSE_W cycles, followed by HOLDOFF
//   idle cycles. A shadow copy of the flop's Q suppresses redundant pulses
//   unless req_force asks for a refresh.
//
//   Parameters: PULSE_W (>=1), HOLDOFF (>=0), CNT_W (pulse counter width)
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     req_valid/req_level/req_force request handshake and payload
//     req_ready                     high in IDLE
//     S, R                          registered set/reset pulses
//     shadow_q                      encoder's model of the flop's Q
//     busy                          pulse or holdoff in progress
//     pulse_cnt                     pulses issued, wraps modulo 2^CNT_W
//     q_fb, fb_err                  readback input and sticky mismatch flag,
//                                   present only with SR_ENC_READBACK_EN
//
//   state | meaning
//   IDLE  | ready; a request that changes the level (or is forced) starts a pulse
//   PULSE | S or R high, timer counts PULSE_W cycles
//   HOLD  | S=R=0, timer counts HOLDOFF cycles before the next request
module sr_pulse_encoder
  import sr_enc_pkg::*;
#(
  parameter int PULSE_W = 1,
  parameter int HOLDOFF = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_level,
  input  logic             req_force,
  output logic             req_ready,
  output logic             S,
  output logic             R,
  output logic             shadow_q,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt
`ifdef SR_ENC_READBACK_EN
  ,
  input  logic             q_fb,
  output logic             fb_err
`endif
);

  localparam int               TMR_W      = tmr_width(PULSE_W, HOLDOFF);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_W - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               shd_q, shd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    s_d     = s_q;
    r_d     = r_q;
    shd_d   = shd_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && (req_force || (req_level != shd_q))) begin
          state_d = PULSE;
          tmr_d   = PULSE_LOAD;
          s_d     = req_level;
          r_d     = ~req_level;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        // s_q holds the requested level for the whole pulse; the flop
        // captures it on the first pulse edge, and so does the shadow.
        shd_d = s_q;
        if (tmr_q == '0) begin
          s_d = 1'b0;
          r_d = 1'b0;
          if (HOLDOFF > 0) begin
            state_d = HOLD;
            tmr_d   = HOLD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      HOLD: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      shd_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      s_q     <= s_d;
      r_q     <= r_d;
      shd_q   <= shd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign S         = s_q;
  assign R         = r_q;
  assign shadow_q  = shd_q;
  assign pulse_cnt = cnt_q;
  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE);

`ifdef SR_ENC_READBACK_EN
  // chk_q marks the cycle right after a pulse ends, so q_fb is compared at
  // edge t0+PULSE_W+1 regardless of whether that falls in HOLD or IDLE.
  logic chk_q, chk_d;
  logic err_q, err_d;

  always_comb begin
    chk_d = (state_q == PULSE) && (tmr_q == '0);
    err_d = err_q | (chk_q & (q_fb != shd_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      err_q <= err_d;
    end
  end

  assign fb_err = err_q;
`endif

endmodule

// File: tb/tb_sr_pulse_encoder.sv
// Bench for sr_pulse_encoder. Two instances share the clock:
//   dut0: PULSE_W=1, HOLDOFF=2, CNT_W=16 (directed start, then random requests)
//   dut1: PULSE_W=3, HOLDOFF=0, CNT_W=2  (reset mid-pulse, alternating levels, wrap)
// Accepted requests push expected pulses into a per-instance queue; a monitor
// on the falling edge pops and checks each pulse the DUT produces.
module tb_sr_pulse_encoder;

  localparam int A_PW = 1, A_HO = 2, A_CW = 16;
  localparam int B_PW = 3, B_HO = 0, B_CW = 2;

  typedef struct {
    logic        level;
    logic        old_shd;
    int unsigned cnt;
    int unsigned edge_no;
  } pulse_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] rst_v = 2'b11;
  logic [1:0] vld   = 2'b00;
  logic [1:0] lvl   = 2'b00;
  logic [1:0] frc   = 2'b00;
  wire  [1:0] rdy, s_o, r_o, shd_o, busy_o;
  wire  [A_CW-1:0] a_cnt;
  wire  [B_CW-1:0] b_cnt;

`ifdef SR_ENC_READBACK_EN
  wire [1:0] err_o;
  logic a_ff = 1'b0;
  // behavioural SR flop driven by dut0
  always @(posedge clk) begin
    if (rst_v[0])    a_ff <= 1'b0;
    else if (s_o[0]) a_ff <= 1'b1;
    else if (r_o[0]) a_ff <= 1'b0;
  end
`endif

  sr_pulse_encoder #(.PULSE_W(A_PW), .HOLDOFF(A_HO), .CNT_W(A_CW)) dut0 (
    .clk(clk), .rst(rst_v[0]), .req_valid(vld[0]), .req_level(lvl[0]),
    .req_force(frc[0]), .req_ready(rdy[0]), .S(s_o[0]), .R(r_o[0]),
    .shadow_q(shd_o[0]), .busy(busy_o[0]), .pulse_cnt(a_cnt)
`ifdef SR_ENC_READBACK_EN
    , .q_fb(a_ff), .fb_err(err_o[0])
`endif
  );

  sr_pulse_encoder #(.PULSE_W(B_PW), .HOLDOFF(B_HO), .CNT_W(B_CW)) dut1 (
    .clk(clk), .rst(rst_v[1]), .req_valid(vld[1]), .req_level(lvl[1]),
    .req_force(frc[1]), .req_ready(rdy[1]), .S(s_o[1]), .R(r_o[1]),
    .shadow_q(shd_o[1]), .busy(busy_o[1]), .pulse_cnt(b_cnt)
`ifdef SR_ENC_READBACK_EN
    , .q_fb(1'b0), .fb_err(err_o[1])
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  pulse_t      exp_q[2][$];
  pulse_t      cur[2];
  bit          in_p[2]     = '{0, 0};
  int          run[2]      = '{0, 0};
  bit          rst_seen[2] = '{1, 1};
  logic        m_shd[2]    = '{0, 0};
  int unsigned m_cnt[2]    = '{0, 0};
  int unsigned m_next[2]   = '{0, 0};
  bit          err_pend[2] = '{0, 0};
  int unsigned err_edge[2] = '{0, 0};
  logic        err_lvl[2]  = '{0, 0};
  logic        m_err[2]    = '{0, 0};

  always @(posedge clk) begin
    rst_seen[0] <= rst_v[0];
    rst_seen[1] <= rst_v[1];
  end

  function automatic int pw(input int id);
    return (id == 0) ? A_PW : B_PW;
  endfunction

  function automatic int ho(input int id);
    return (id == 0) ? A_HO : B_HO;
  endfunction

  function automatic int unsigned cmask(input int id);
    return (id == 0) ? ((1 << A_CW) - 1) : ((1 << B_CW) - 1);
  endfunction

  function automatic logic [31:0] cnt_of(input int id);
    return (id == 0) ? 32'(a_cnt) : 32'(b_cnt);
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d, want %0d (cycle %0d)", name, id, act, want, cyc);
    end
  endtask

  // Present a request at a falling edge and hold it until accepted.
  task automatic send(input int id, input logic level, input logic force_in);
    int          budget;
    int unsigned exp_edge;
    int unsigned acc_edge;
    bit          pulse;
    vld[id] = 1'b1;
    lvl[id] = level;
    frc[id] = force_in;
    exp_edge = (cyc + 1 > m_next[id]) ? cyc + 1 : m_next[id];
    budget = 0;
    while (!rdy[id] && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!rdy[id]) begin
      n_chk++;
      n_bad++;
      $display("FAIL accept_timeout dut%0d: got ready=0 for 50 cycles, want ready=1", id);
      vld[id] = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    chk("accept_edge", id, acc_edge, exp_edge);
    pulse = force_in || (level != m_shd[id]);
    if (pulse) begin
      m_cnt[id] = (m_cnt[id] + 1) & cmask(id);
      exp_q[id].push_back('{level, m_shd[id], m_cnt[id], acc_edge});
      m_shd[id]  = level;
      m_next[id] = acc_edge + pw(id) + ho(id) + 1;
    end else begin
      m_next[id] = acc_edge + 1;
    end
    @(negedge clk);
    vld[id] = 1'b0;
    frc[id] = 1'b0;
    if (!pulse) begin
      chk("noop_ready", id, 32'(rdy[id]), 1);
      chk("noop_cnt", id, cnt_of(id), m_cnt[id]);
    end
  endtask

  task automatic mon(input int id);
    logic fbv;
    chk("s_and_r_exclusive", id, 32'(s_o[id] & r_o[id]), 0);
    chk("busy_vs_ready", id, 32'(busy_o[id]), 32'(!rdy[id]));
    if (rst_seen[id]) begin
      in_p[id]     = 1'b0;
      err_pend[id] = 1'b0;
      m_err[id]    = 1'b0;
      exp_q[id].delete();
`ifdef SR_ENC_READBACK_EN
      chk("fb_err_reset", id, 32'(err_o[id]), 0);
`endif
      return;
    end
`ifdef SR_ENC_READBACK_EN
    if (err_pend[id] && cyc == err_edge[id]) begin
      err_pend[id] = 1'b0;
      // dut0 reads back a real flop (follows the pulse); dut1 reads a constant 0
      fbv = (id == 0) ? err_lvl[id] : 1'b0;
      if (fbv != err_lvl[id]) m_err[id] = 1'b1;
    end
    chk("fb_err", id, 32'(err_o[id]), 32'(m_err[id]));
`else
    fbv = 1'b0;
`endif
    if (s_o[id] | r_o[id]) begin
      if (!in_p[id]) begin
        in_p[id] = 1'b1;
        run[id]  = 1;
        n_chk++;
        if (exp_q[id].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse dut%0d: got S=%0d R=%0d, want no pulse (cycle %0d)",
                   id, s_o[id], r_o[id], cyc);
          cur[id] = '{s_o[id], shd_o[id], 0, cyc};
        end else begin
          cur[id] = exp_q[id].pop_front();
          chk("pulse_start_edge", id, cyc, cur[id].edge_no);
          chk("pulse_S", id, 32'(s_o[id]), 32'(cur[id].level));
          chk("pulse_R", id, 32'(r_o[id]), 32'(!cur[id].level));
          chk("pulse_cnt", id, cnt_of(id), cur[id].cnt);
          chk("shadow_before", id, 32'(shd_o[id]), 32'(cur[id].old_shd));
          err_pend[id] = 1'b1;
          err_edge[id] = cur[id].edge_no + pw(id) + 1;
          err_lvl[id]  = cur[id].level;
        end
      end else begin
        run[id]++;
        chk("pulse_hold_S", id, 32'(s_o[id]), 32'(cur[id].level));
        chk("shadow_during", id, 32'(shd_o[id]), 32'(cur[id].level));
      end
    end else if (in_p[id]) begin
      in_p[id] = 1'b0;
      chk("pulse_width", id, run[id], pw(id));
      chk("shadow_after", id, 32'(shd_o[id]), 32'(cur[id].level));
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      chk("rst_S", id, 32'(s_o[id]), 0);
      chk("rst_R", id, 32'(r_o[id]), 0);
      chk("rst_shadow", id, 32'(shd_o[id]), 0);
      chk("rst_busy", id, 32'(busy_o[id]), 0);
      chk("rst_ready", id, 32'(rdy[id]), 1);
      chk("rst_cnt", id, cnt_of(id), 0);
    end
    rst_v = 2'b00;
    @(negedge clk);

    // dut0: set pulse, no-op, forced refresh, reset pulse, then random traffic
    send(0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b1);
    send(0, 1'b0, 1'b0);
    repeat (80) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    repeat (8) @(negedge clk);
    chk("a_queue_drained", 0, exp_q[0].size(), 0);
    chk("a_final_cnt", 0, cnt_of(0), m_cnt[0]);
    chk("a_final_shadow", 0, 32'(shd_o[0]), 32'(m_shd[0]));

    // dut1: reset during the second cycle of a 3-cycle S pulse
    send(1, 1'b1, 1'b0);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    chk("midrst_S", 1, 32'(s_o[1]), 0);
    chk("midrst_R", 1, 32'(r_o[1]), 0);
    chk("midrst_shadow", 1, 32'(shd_o[1]), 0);
    chk("midrst_ready", 1, 32'(rdy[1]), 1);
    chk("midrst_busy", 1, 32'(busy_o[1]), 0);
    chk("midrst_cnt", 1, cnt_of(1), 0);
    rst_v[1]  = 1'b0;
    m_shd[1]  = 1'b0;
    m_cnt[1]  = 0;
    m_next[1] = 0;
    @(negedge clk);
    // levels 1,0,1,0,1 back to back: counter reads 1,2,3,0,1
    for (int i = 0; i < 5; i++) send(1, 1'((i % 2) == 0), 1'b0);
    repeat (8) @(negedge clk);
    chk("b_queue_drained", 1, exp_q[1].size(), 0);
    chk("b_final_cnt", 1, cnt_of(1), m_cnt[1]);
    chk("b_final_shadow", 1, 32'(shd_o[1]), 32'(m_shd[1]));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test by cycle %0d, want end before limit", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sr_pulse_encoder.md
# sr_pulse_encoder

Command-side driver for the team's SR flip-flop (ports clk, rst, S, R, Q). Accepts target-level requests over a valid/ready handshake and emits timed single-rail S or R pulses, so that S and R are never asserted together. Keeps a shadow copy of the downstream Q and only pulses on a change, unless a refresh is forced. Sits between control logic and any SR flip-flop that shares its clk and rst.

## Interface
- PULSE_W, 1: cycles each S/R pulse is held high; legal range is 1 or more.
- HOLDOFF, 2: idle cycles enforced after a pulse before the next request is accepted; legal range is 0 or more.
- CNT_W, 16: width of the pulse counter.
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is present.
- req_level  in  1  target Q level: 1 means set, 0 means reset.
- req_force  in  1  pulse even when req_level equals shadow_q (refresh).
- req_ready  out  1  encoder can accept a request this cycle.
- S  out  1  registered set pulse to the flip-flop.
- R  out  1  registered reset pulse to the flip-flop.
- shadow_q  out  1  encoder's model of the flip-flop's Q.
- busy  out  1  a pulse or holdoff is in progress.
- pulse_cnt  out  CNT_W  number of pulses issued; wraps modulo 2^CNT_W.
- q_fb  in  1  Q read back from the flip-flop. Present only with SR_ENC_READBACK_EN.
- fb_err  out  1  sticky readback mismatch flag. Present only with SR_ENC_READBACK_EN.

## Operation
- Reset values: S=0, R=0, shadow_q=0 (matches the flip-flop's reset value), busy=0, pulse_cnt=0, fb_err=0, req_ready=1, state IDLE.
- States: IDLE, PULSE, HOLD.
- **IDLE**
  - req_ready=1.
  - A request is accepted when req_valid & req_ready is sampled at an edge.
  - If req_level != shadow_q, or req_force=1: go to PULSE. Register S=req_level and R=~req_level. Increment pulse_cnt.
  - Otherwise the request is consumed with no pulse and the state stays IDLE.
- **PULSE**
  - S or R is held high for exactly PULSE_W cycles.
  - shadow_q takes req_level at the first edge of the pulse, the same edge at which the flip-flop updates Q.
  - At the end of the pulse, S and R both drop to 0. Go to HOLD if HOLDOFF>0, else go to IDLE.
- **HOLD**
  - Count HOLDOFF cycles with S=R=0, then return to IDLE.
- S & R = 1 is never produced, in any state, across reset, or with any parameter values.
- busy = (state != IDLE). req_ready = (state == IDLE).
- Inputs are ignored when req_ready=0. Requests are not queued; the producer must hold req_valid until it is accepted.
- pulse_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- Reset asserted mid-PULSE or mid-HOLD: all outputs return to their reset values at that edge. S and R are low from the next cycle. Any in-flight request is lost.

## Timing
- Request accepted at edge t0:
  - S or R is high in cycles t0+1 through t0+PULSE_W.
  - shadow_q changes at edge t0+1.
  - req_ready rises after edge t0+PULSE_W+HOLDOFF.
- Request-to-request spacing is PULSE_W+HOLDOFF+1 cycles. With the defaults this is 4 cycles.
- A no-op request (no level change, no force): req_ready stays high. Back-to-back no-op requests are accepted every cycle.
- Every output is registered; there are no combinational input-to-output paths except req_ready, which is decoded from state.

## Configuration
- SR_ENC_READBACK_EN defined:
  - q_fb and fb_err ports exist.
  - q_fb is sampled at the first edge after each pulse ends, i.e. edge t0+PULSE_W+1, which may fall in HOLD or IDLE.
  - If q_fb != shadow_q at that edge, fb_err is set.
  - fb_err stays set until rst.
- SR_ENC_READBACK_EN undefined: the ports are absent and no check logic is built.

## Structure
- Shared package sr_enc_pkg holds:
  - the state enum (IDLE, PULSE, HOLD);
  - the localparam width rule for the timer: $clog2 of max(PULSE_W, HOLDOFF)+1.
- No sub-module. One down-counter is shared between the PULSE and HOLD phases inside sr_pulse_encoder.

## Test plan
- Default parameters, request level=1 accepted at edge 0:
  - S high in cycle 1 only; R stays 0.
  - shadow_q=1 after edge 1.
  - req_ready returns high after edge 3.
  - pulse_cnt=1.
- Request level=1 while shadow_q=1, force=0:
  - no pulse; pulse_cnt unchanged; req_ready stays 1.
  - Repeat with force=1: an S pulse is issued and pulse_cnt increments.
- PULSE_W=3, HOLDOFF=0, alternating levels 1, 0, 1 with req_valid held high:
  - S high for 3 cycles, then R high for 3 cycles, then S high for 3 cycles.
  - Accept edges are spaced 4 cycles apart.
- rst asserted during the second cycle of a PULSE_W=3 S pulse:
  - S=0 from the next cycle; shadow_q=0; req_ready=1.
  - A following level=1 request pulses S again.
- CNT_W=2, 5 pulses: pulse_cnt reads 1, 2, 3, 0, 1.
- SR_ENC_READBACK_EN, q_fb tied to 0, level=1 request:
  - fb_err=1 after edge PULSE_W+1 and stays set until rst.
  - Wired to a real SR flip-flop instead: fb_err stays 0.
